// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V width codes, FSM
// state encoding and the byte-lane helper functions.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } lsu_state_e;

  // Access size in bytes; 0 for codes that are not a width at all.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      F3_B, F3_BU: size = 3'd1;
      F3_H, F3_HU: size = 3'd2;
      F3_W:        size = 3'd4;
      default:     size = 3'd0;
    endcase
    return size;
  endfunction

  function automatic logic access_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    if (we) ok = funct3 inside {F3_B, F3_H, F3_W};
    else    ok = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    return ok;
  endfunction

  // Lanes lo..hi-1 set, lanes outside 0..3 silently dropped.
  function automatic logic [3:0] lane_mask(input logic [3:0] lo, input logic [3:0] hi);
    logic [3:0] mask;
    mask = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      mask[k] = (4'(k) >= lo) && (4'(k) < hi);
    end
    return mask;
  endfunction

  function automatic logic [31:0] rotate_lanes(input logic [31:0] w, input logic [1:0] off);
    logic [31:0] r;
    case (off)
      2'd0:    r = w;
      2'd1:    r = {w[23:0], w[31:24]};
      2'd2:    r = {w[15:0], w[31:16]};
      default: r = {w[7:0],  w[31:8]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the {high,low} word pair down by the byte
// offset and sign/zero-extends to 32 bits according to the width code.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] low_word,
  input  logic [31:0] high_word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [63:0] pair;
  logic [31:0] raw;

  always_comb begin
    pair = {high_word, low_word} >> {byte_off, 3'b000};
    raw  = pair[31:0];
    case (funct3)
      F3_B:    rdata = {{24{raw[7]}},  raw[7:0]};
      F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
      F3_W:    rdata = raw;
      F3_BU:   rdata = {24'h0, raw[7:0]};
      F3_HU:   rdata = {16'h0, raw[15:0]};
      default: rdata = '0;
    endcase
  end

  logic unused_pair_high;
  assign unused_pair_high = ^pair[63:32];

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit for a byte-lane word memory; unaligned
// accesses crossing a word boundary are split into two memory cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [3:0]            mem_byte_sel,
  input  logic [31:0]           mem_rdata
);

  lsu_state_e            state;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [3:0]            end_q;
  logic                  split_q;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [31:0]           wdata_rot_q;
  logic [31:0]           low_q;

  logic [1:0]  req_off;
  logic [3:0]  req_end;
  logic [31:0] align_low;
  logic [31:0] align_high;
  logic [31:0] load_data;

  assign req_ready = (state == IDLE);
  assign req_off   = req_addr[1:0];
  assign req_end   = {2'b00, req_off} + {1'b0, access_size(req_funct3)};

  // In WAIT, mem_rdata holds the low word (non-split) or the high word (split).
  assign align_low  = split_q ? low_q : mem_rdata;
  assign align_high = split_q ? mem_rdata : '0;

  lsu_load_align u_align (
    .low_word  (align_low),
    .high_word (align_high),
    .byte_off  (off_q),
    .funct3    (funct3_q),
    .rdata     (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      end_q        <= '0;
      split_q      <= 1'b0;
      word_q       <= '0;
      wdata_rot_q  <= '0;
      low_q        <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_error   <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      mem_re       <= 1'b0;
      mem_byte_sel <= '0;
    end else begin
      resp_valid   <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      mem_re       <= 1'b0;
      mem_byte_sel <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            funct3_q    <= req_funct3;
            off_q       <= req_off;
            end_q       <= req_end;
            split_q     <= (req_end > 4'd4);
            word_q      <= req_addr[ADDR_WIDTH+1:2];
            wdata_rot_q <= rotate_lanes(req_wdata, req_off);
            if (!access_legal(req_we, req_funct3)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state        <= ACC0;
              mem_addr     <= req_addr[ADDR_WIDTH+1:2];
              mem_wdata    <= rotate_lanes(req_wdata, req_off);
              mem_we       <= req_we;
              mem_re       <= !req_we;
              mem_byte_sel <= lane_mask({2'b00, req_off}, req_end);
            end
          end
        end
        ACC0: begin
          if (split_q) begin
            state        <= ACC1;
            mem_addr     <= word_q + ADDR_WIDTH'(1);
            mem_wdata    <= wdata_rot_q;
            mem_we       <= we_q;
            mem_re       <= !we_q;
            mem_byte_sel <= lane_mask(4'd0, end_q - 4'd4);
          end else begin
            state <= WAIT;
          end
        end
        ACC1: begin
          low_q <= mem_rdata;
          state <= WAIT;
        end
        WAIT: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= we_q ? '0 : load_data;
        end
        RESP: begin
          state      <= IDLE;
          resp_rdata <= '0;
          resp_error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte-lane memory model answers the
// unit, and hand-computed vectors check timing, lanes and load data.
module tb_load_store_unit;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [3:0]    mem_byte_sel;
  logic [31:0]   mem_rdata;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] c_addr  [1:2];
  logic [3:0]    c_sel   [1:2];
  logic [31:0]   c_wdata [1:2];
  logic          c_we    [1:2];
  logic          saw_re, saw_we;
  int            n_resp;

  int          lat;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_byte_sel (mem_byte_sel),
    .mem_rdata    (mem_rdata)
  );

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (mem_we) begin
      for (int k = 0; k < 4; k++)
        if (mem_byte_sel[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Issue one request and watch a fixed window of cycles; cycle 1 is ACC0.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    lat = -1; rd = '0; er = 1'b0; n_resp = 0; saw_re = 1'b0; saw_we = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      c_addr[i] = '0; c_sel[i] = '0; c_wdata[i] = '0; c_we[i] = 1'b0;
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 2) begin
        c_addr[c] = mem_addr; c_sel[c] = mem_byte_sel;
        c_wdata[c] = mem_wdata; c_we[c] = mem_we;
      end
      if (mem_re) saw_re = 1'b1;
      if (mem_we) saw_we = 1'b1;
      if (resp_valid) begin
        n_resp++;
        if (lat < 0) begin lat = c; rd = resp_rdata; er = resp_error; end
      end
    end
  endtask

  task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input int exp_lat, input logic [31:0] exp_rd);
    run_req(1'b0, f3, addr, 32'h0);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, rd, exp_rd);
    check({tag, "_err"}, {31'h0, er}, 32'h0);
    check({tag, "_pulse"}, 32'(n_resp), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_mem_en", {30'h0, mem_we, mem_re}, 32'h0);
    check("rst_sel", {28'h0, mem_byte_sel}, 32'h0);

    // Byte/half loads from a single word
    preload(0, 32'h8899AABB);
    run_req(1'b0, F3_B_C(), 32'h2, 32'h0);
    check("lb_sel", {28'h0, c_sel[1]}, 32'h4);
    check("lb_addr", 32'(c_addr[1]), 32'h0);
    check("lb_lat", 32'(lat), 32'd3);
    check("lb_data", rd, 32'hFFFFFF99);
    check("lb_pulse", 32'(n_resp), 32'd1);
    load_check("lbu3", 3'b100, 32'h3, 3, 32'h00000088);
    load_check("lh0", 3'b001, 32'h0, 3, 32'hFFFFAABB);
    load_check("lhu2", 3'b101, 32'h2, 3, 32'h00008899);

    // Split word store and readback
    preload(1, 32'h0);
    preload(2, 32'h0);
    run_req(1'b1, 3'b010, 32'h5, 32'hDEADBEEF);
    check("sw_acc0_addr", 32'(c_addr[1]), 32'h1);
    check("sw_acc0_sel", {28'h0, c_sel[1]}, 32'hE);
    check("sw_acc0_wd", c_wdata[1], 32'hADBEEFDE);
    check("sw_acc0_we", {31'h0, c_we[1]}, 32'h1);
    check("sw_acc1_addr", 32'(c_addr[2]), 32'h2);
    check("sw_acc1_sel", {28'h0, c_sel[2]}, 32'h1);
    check("sw_acc1_wd", c_wdata[2], 32'hADBEEFDE);
    check("sw_lat", 32'(lat), 32'd4);
    check("sw_rdata", rd, 32'h0);
    check("sw_no_re", {31'h0, saw_re}, 32'h0);
    check("sw_mem1", mem[1], 32'hADBEEF00);
    check("sw_mem2", mem[2], 32'h000000DE);
    load_check("lw5", 3'b010, 32'h5, 4, 32'hDEADBEEF);

    // Sub-word stores merge into a word
    preload(6, 32'h0);
    run_req(1'b1, 3'b001, 32'h1A, 32'h00001234);
    check("sh_sel", {28'h0, c_sel[1]}, 32'hC);
    check("sh_wd", c_wdata[1], 32'h12340000);
    run_req(1'b1, 3'b000, 32'h1B, 32'h0000005A);
    check("sb_sel", {28'h0, c_sel[1]}, 32'h8);
    check("sb_lat", 32'(lat), 32'd3);
    load_check("lw18", 3'b010, 32'h18, 3, 32'h5A340000);

    // Split half loads across words 0/1
    preload(0, 32'h11223344);
    preload(1, 32'h55667788);
    run_req(1'b0, 3'b101, 32'h3, 32'h0);
    check("lhu3_sel0", {28'h0, c_sel[1]}, 32'h8);
    check("lhu3_sel1", {28'h0, c_sel[2]}, 32'h1);
    check("lhu3_addr1", 32'(c_addr[2]), 32'h1);
    check("lhu3_lat", 32'(lat), 32'd4);
    check("lhu3_data", rd, 32'h00008811);
    load_check("lh3", 3'b001, 32'h3, 4, 32'hFFFF8811);
    load_check("lbu1", 3'b100, 32'h1, 3, 32'h00000033);
    load_check("lh2", 3'b001, 32'h2, 3, 32'h00001122);
    load_check("lw_hi_bits", 3'b010, 32'hFFFF0004, 3, 32'h55667788);

    // Illegal width codes
    run_req(1'b0, 3'b011, 32'h0, 32'h0);
    check("ill_ld_lat", 32'(lat), 32'd1);
    check("ill_ld_err", {31'h0, er}, 32'h1);
    check("ill_ld_no_re", {31'h0, saw_re}, 32'h0);
    check("ill_ld_pulse", 32'(n_resp), 32'd1);
    run_req(1'b1, 3'b100, 32'h0, 32'hFFFFFFFF);
    check("ill_st_lat", 32'(lat), 32'd1);
    check("ill_st_err", {31'h0, er}, 32'h1);
    check("ill_st_no_we", {31'h0, saw_we}, 32'h0);
    check("ill_st_mem0", mem[0], 32'h11223344);
    run_req(1'b0, 3'b111, 32'h0, 32'h0);
    check("ill_ld7_err", {31'h0, er}, 32'h1);

    // Address wrap at the top of memory
    preload(14'h3FFF, 32'hA1B2C3D4);
    run_req(1'b0, 3'b010, 32'h0000FFFE, 32'h0);
    check("wrap_addr0", 32'(c_addr[1]), 32'h3FFF);
    check("wrap_addr1", 32'(c_addr[2]), 32'h0);
    check("wrap_sel1", {28'h0, c_sel[2]}, 32'h3);
    check("wrap_lat", 32'(lat), 32'd4);
    check("wrap_data", rd, 32'h3344A1B2);

    // Reset while a split store is in flight: second half must never issue
    preload(1, 32'h0);
    preload(2, 32'h12345678);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h6; req_wdata = 32'hCAFEBABE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_acc0_we", {31'h0, mem_we}, 32'h1);
    check("mid_acc0_sel", {28'h0, mem_byte_sel}, 32'hC);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_we", {31'h0, mem_we}, 32'h0);
    check("mid_rst_sel", {28'h0, mem_byte_sel}, 32'h0);
    check("mid_rst_resp", {31'h0, resp_valid}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_ready", {31'h0, req_ready}, 32'h1);
    n_resp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_we) n_resp++;
    end
    check("mid_quiet", 32'(n_resp), 32'd0);
    check("mid_mem1", mem[1], 32'hBABE0000);
    check("mid_mem2", mem[2], 32'h12345678);
    load_check("post_rst_lw", 3'b010, 32'h4, 3, 32'hBABE0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic logic [2:0] F3_B_C();
    return 3'b000;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
